// File: rtl/apb_resp_pkg.sv
// Shared types and helpers for the multi-bank APB completer.
package apb_resp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam int ADDR_LSB   = 2;
  localparam int MAX_SLAVES = 32;

  // Callers zero-extend their select vector to MAX_SLAVES; one-hotness is unaffected.
  function automatic logic is_onehot(input logic [MAX_SLAVES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic int idx_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < depth) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/apb_resp_mem.sv
// Register banks, one per select line; one write port, one combinational read port.
module apb_resp_mem #(
  parameter int NUM_SLAVES = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_W     = 32,
  parameter int BW         = 2,
  parameter int IW         = 4
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              we,
  input  logic [BW-1:0]     wbank,
  input  logic [IW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BW-1:0]     rbank,
  input  logic [IW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_SLAVES][DEPTH];

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int b = 0; b < NUM_SLAVES; b++)
        for (int w = 0; w < DEPTH; w++)
          mem[b][w] <= '0;
    end else if (we) begin
      mem[wbank][widx] <= wdata;
    end
  end

  assign rdata = mem[rbank][ridx];

endmodule

// File: rtl/apb_multi_slave_responder.sv
// APB completer with NUM_SLAVES register banks, programmable wait states,
// error response on illegal transfers and a sticky protocol-violation flag.
//
// state     | meaning
// ST_IDLE   | waiting for a SETUP phase (select high, Penable low)
// ST_ACCESS | transfer captured; counting wait states, then completing
module apb_multi_slave_responder
  import apb_resp_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 16,
  parameter int WAIT_W     = 3
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_SLAVES-1:0] Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_W-1:0]     Paddr,
  input  logic [DATA_W-1:0]     Pwdata,
  output logic [DATA_W-1:0]     Prdata,
  output logic                  Pready,
  output logic                  Pslverr,
  input  logic [WAIT_W-1:0]     wait_cfg,
  output logic                  proto_err,
  input  logic                  proto_err_clr
);

  localparam int IW = idx_w(DEPTH);
  localparam int BW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_t                state;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [BW-1:0]         bank_q, bank_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wr_q, err_q, err_d;
  logic [DATA_W-1:0]     wdata_q, rdata_mem;
  logic [WAIT_W-1:0]     cnt;
  logic                  setup, idle_viol, acc_ok, acc_viol, mem_we;

  always_comb begin
    bank_d = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (Pselx[i]) bank_d = BW'(i);
  end

  assign idx_d = Paddr[ADDR_LSB +: IW];
  assign err_d = !is_onehot(MAX_SLAVES'(Pselx))
               || (Paddr[ADDR_LSB-1:0] != '0)
               || ((Paddr >> (ADDR_LSB + IW)) != '0);

  assign setup     = (state == ST_IDLE) && (|Pselx) && !Penable;
  assign idle_viol = (state == ST_IDLE) && Penable;
  assign acc_ok    = (state == ST_ACCESS) && Penable && (Pselx == sel_q);
  assign acc_viol  = (state == ST_ACCESS) && !acc_ok;
  // Only the completion edge of a clean, legal write commits to the bank.
  assign mem_we    = acc_ok && Pready && wr_q && !err_q;

  apb_resp_mem #(
    .NUM_SLAVES(NUM_SLAVES),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .BW        (BW),
    .IW        (IW)
  ) u_mem (
    .Hclk   (Hclk),
    .Hresetn(Hresetn),
    .we     (mem_we),
    .wbank  (bank_q),
    .widx   (idx_q),
    .wdata  (wdata_q),
    .rbank  (bank_d),
    .ridx   (idx_d),
    .rdata  (rdata_mem)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      bank_q    <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      Prdata    <= '0;
      Pready    <= 1'b0;
      Pslverr   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (idle_viol || acc_viol)
        proto_err <= 1'b1;
      else if (proto_err_clr)
        proto_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (setup) begin
            sel_q   <= Pselx;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            wr_q    <= Pwrite;
            err_q   <= err_d;
            wdata_q <= Pwdata;
            cnt     <= wait_cfg;
            if (!Pwrite)
              Prdata <= err_d ? '0 : rdata_mem;
            Pready  <= (wait_cfg == '0);
            Pslverr <= err_d && (wait_cfg == '0);
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (acc_ok && Pready) begin
            Pready  <= 1'b0;
            Pslverr <= 1'b0;
            state   <= ST_IDLE;
          end else if (acc_ok) begin
            cnt     <= cnt - WAIT_W'(1);
            Pready  <= (cnt == WAIT_W'(1));
            Pslverr <= err_q && (cnt == WAIT_W'(1));
          end else begin
            Pready  <= 1'b0;
            Pslverr <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_responder.sv
// Directed bench for apb_multi_slave_responder with hand-computed expectations.
module tb_apb_multi_slave_responder;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;
  logic [2:0]  wait_cfg;
  logic        proto_err;
  logic        proto_err_clr;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] rd;
  logic        err;
  logic        stable;
  int          ncyc;

  apb_multi_slave_responder dut (
    .Hclk         (Hclk),
    .Hresetn      (Hresetn),
    .Pselx        (Pselx),
    .Penable      (Penable),
    .Pwrite       (Pwrite),
    .Paddr        (Paddr),
    .Pwdata       (Pwdata),
    .Prdata       (Prdata),
    .Pready       (Pready),
    .Pslverr      (Pslverr),
    .wait_cfg     (wait_cfg),
    .proto_err    (proto_err),
    .proto_err_clr(proto_err_clr)
  );

  always #5 Hclk = ~Hclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the completion edge.
  // wait_cfg is scrambled after SETUP to show it is not re-sampled.
  task automatic xfer(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [2:0] wc,
                      output logic [31:0] rdo, output logic erro, output int ncyco,
                      output logic stab);
    logic [31:0] first;
    Pselx = sel; Paddr = addr; Pwrite = wr; Pwdata = wd; wait_cfg = wc; Penable = 1'b0;
    tick();
    Penable  = 1'b1;
    wait_cfg = ~wc;
    ncyco    = 1;
    first    = Prdata;
    stab     = 1'b1;
    while (!Pready && ncyco < 20) begin
      tick();
      ncyco++;
      if (Prdata !== first) stab = 1'b0;
    end
    rdo  = Prdata;
    erro = Pslverr;
    tick();
    Penable = 1'b0;
    Pselx   = '0;
    check_val("rdy_one_cycle", {31'd0, Pready}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Hresetn = 1'b0; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0;
    Pwdata = '0; wait_cfg = '0; proto_err_clr = 1'b0;
    tick(); tick();
    check_val("rst_prdata", Prdata, 32'd0);
    check_val("rst_pready", {31'd0, Pready}, 32'd0);
    check_val("rst_pslverr", {31'd0, Pslverr}, 32'd0);
    check_val("rst_proto_err", {31'd0, proto_err}, 32'd0);
    Hresetn = 1'b1;
    tick();

    // Zero-wait write and read-back; other bank untouched
    xfer(4'b0010, 32'h8, 1'b1, 32'hDEADBEEF, 3'd0, rd, err, ncyc, stable);
    check_val("wr0_cycles", ncyc, 1);
    check_val("wr0_err", {31'd0, err}, 32'd0);
    xfer(4'b0010, 32'h8, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("rd_b1_8", rd, 32'hDEADBEEF);
    check_val("rd_b1_8_cycles", ncyc, 1);
    xfer(4'b0001, 32'h8, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("rd_b0_8", rd, 32'h0);

    // Three wait states, Prdata stable throughout ACCESS
    xfer(4'b0001, 32'h4, 1'b1, 32'h12345678, 3'd0, rd, err, ncyc, stable);
    xfer(4'b0001, 32'h4, 1'b0, 32'h0, 3'd3, rd, err, ncyc, stable);
    check_val("w3_cycles", ncyc, 4);
    check_val("w3_data", rd, 32'h12345678);
    check_val("w3_stable", {31'd0, stable}, 32'd1);
    check_val("w3_err", {31'd0, err}, 32'd0);

    // Illegal transfers
    xfer(4'b0011, 32'h4, 1'b1, 32'h55, 3'd0, rd, err, ncyc, stable);
    check_val("multisel_err", {31'd0, err}, 32'd1);
    xfer(4'b0001, 32'h40, 1'b1, 32'h55, 3'd1, rd, err, ncyc, stable);
    check_val("hiaddr_wr_err", {31'd0, err}, 32'd1);
    check_val("hiaddr_wr_cycles", ncyc, 2);
    xfer(4'b0001, 32'h40, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("hiaddr_rd_err", {31'd0, err}, 32'd1);
    check_val("hiaddr_rd_data", rd, 32'h0);
    xfer(4'b0010, 32'h6, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("misalign_err", {31'd0, err}, 32'd1);
    xfer(4'b0001, 32'h4, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("noerr_b0_4", rd, 32'h12345678);
    check_val("noerr_flag", {31'd0, err}, 32'd0);
    xfer(4'b0010, 32'h4, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("noerr_b1_4", rd, 32'h0);
    xfer(4'b0001, 32'h0, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("noerr_b0_0", rd, 32'h0);

    // Back-to-back write then read, no idle cycle between them
    xfer(4'b0100, 32'h0, 1'b1, 32'h1, 3'd0, rd, err, ncyc, stable);
    xfer(4'b0100, 32'h0, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("b2b_data", rd, 32'h1);
    check_val("b2b_cycles", ncyc, 1);

    // Penable dropped in second ACCESS cycle of a two-wait write
    Pselx = 4'b1000; Paddr = 32'hC; Pwrite = 1'b1; Pwdata = 32'hAA; wait_cfg = 3'd2;
    tick();
    Penable = 1'b1;
    tick();
    Penable = 1'b0;
    tick();
    Pselx = '0;
    check_val("abort_proto_err", {31'd0, proto_err}, 32'd1);
    check_val("abort_pready", {31'd0, Pready}, 32'd0);
    proto_err_clr = 1'b1;
    tick();
    proto_err_clr = 1'b0;
    check_val("clr_proto_err", {31'd0, proto_err}, 32'd0);
    xfer(4'b1000, 32'hC, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("abort_no_write", rd, 32'h0);

    // Penable in IDLE sets the flag, and setting beats a simultaneous clear
    Penable = 1'b1;
    tick();
    check_val("idle_viol", {31'd0, proto_err}, 32'd1);
    proto_err_clr = 1'b1;
    tick();
    check_val("set_beats_clr", {31'd0, proto_err}, 32'd1);
    Penable = 1'b0;
    tick();
    proto_err_clr = 1'b0;
    check_val("clr_after", {31'd0, proto_err}, 32'd0);

    // Reset during a five-wait write
    xfer(4'b0100, 32'h0, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    Pselx = 4'b0010; Paddr = 32'h0; Pwrite = 1'b1; Pwdata = 32'h77; wait_cfg = 3'd5;
    tick();
    Penable = 1'b1;
    tick(); tick();
    check_val("pre_rst_prdata", Prdata, 32'h1);
    Hresetn = 1'b0;
    #1;
    check_val("midrst_prdata", Prdata, 32'h0);
    check_val("midrst_pready", {31'd0, Pready}, 32'd0);
    check_val("midrst_pslverr", {31'd0, Pslverr}, 32'd0);
    check_val("midrst_proto_err", {31'd0, proto_err}, 32'd0);
    Pselx = '0; Penable = 1'b0;
    tick();
    Hresetn = 1'b1;
    tick();
    xfer(4'b0010, 32'h8, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("post_rst_b1_8", rd, 32'h0);
    xfer(4'b0100, 32'h0, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("post_rst_b2_0", rd, 32'h0);
    xfer(4'b0010, 32'h0, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("post_rst_b1_0", rd, 32'h0);
    xfer(4'b0001, 32'h4, 1'b0, 32'h0, 3'd0, rd, err, ncyc, stable);
    check_val("post_rst_b0_4", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
